// File: rtl/smoldvi_pkg.sv
// Shared types, standard video timings and helpers for the smoldvi timing path.
package smoldvi_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_RUN   = 2'd1;
  localparam logic [1:0] ENC_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_RUN   = ENC_RUN,
    ST_DRAIN = ENC_DRAIN
  } state_t;

  // 640x480@60, negative syncs
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 800x600@60, positive syncs
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync_w, input int bp);
    return active + fp + sync_w + bp;
  endfunction

  function automatic logic sync_level(input logic act, input logic pol);
    return act ? pol : ~pol;
  endfunction

endpackage

// File: rtl/smoldvi_sync_delay.sv
// Fixed-depth shift register for the {vsync, hsync, den} bundle; DEPTH=0 is a wire.
module smoldvi_sync_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst, rst_val};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stage_p [DEPTH];

    // Every stage reloads the blank value so nothing stale survives a reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_p[i] <= rst_val;
      end else begin
        stage_p[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign q = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/smoldvi_timing.sv
// Video timing controller: h/v counters, pixel fetch requests and latency-matched syncs.
module smoldvi_timing
  import smoldvi_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int PIPE_LATENCY = 2,
  parameter int W_COORD      = 10
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               en,
  output logic               running,
  output logic               req_valid,
  output logic [W_COORD-1:0] req_x,
  output logic [W_COORD-1:0] req_y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vsync,
  output logic               hsync,
  output logic               den
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [W_COORD-1:0] H_LAST   = W_COORD'(H_TOTAL - 1);
  localparam logic [W_COORD-1:0] V_LAST   = W_COORD'(V_TOTAL - 1);
  localparam logic [W_COORD-1:0] H_ACT    = W_COORD'(H_ACTIVE);
  localparam logic [W_COORD-1:0] V_ACT    = W_COORD'(V_ACTIVE);
  localparam logic [W_COORD-1:0] HS_FIRST = W_COORD'(H_ACTIVE + H_FP);
  localparam logic [W_COORD-1:0] HS_LAST  = W_COORD'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [W_COORD-1:0] VS_FIRST = W_COORD'(V_ACTIVE + V_FP);
  localparam logic [W_COORD-1:0] VS_LAST  = W_COORD'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [2:0] BLANK = {~VSYNC_POL, ~HSYNC_POL, 1'b0};

  state_t               st, st_nxt;
  logic [W_COORD-1:0]   h_cnt, v_cnt, h_nxt, v_nxt, v_after;
  logic                 h_wrap, frame_end, run_nxt;
  logic                 vld_nxt, ls_nxt, fs_nxt, hs_nxt, vs_nxt;

  logic                 vld_p0, ls_p0, fs_p0, hs_p0, vs_p0;
  logic [W_COORD-1:0]   x_p0, y_p0;
  logic [2:0]           sync_d, sync_q;

  always_comb begin
    st_nxt    = st;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    h_wrap    = (h_cnt == H_LAST);
    frame_end = h_wrap && (v_cnt == V_LAST);

    case (st)
      ST_IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (en) st_nxt = ST_RUN;
      end
      default: begin
        h_nxt = h_wrap ? '0 : h_cnt + W_COORD'(1);
        if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + W_COORD'(1);
        // en only matters at the frame edge for stopping; DRAIN just remembers it fell.
        if (frame_end)                   st_nxt = en ? ST_RUN : ST_IDLE;
        else if (st == ST_RUN && !en)    st_nxt = ST_DRAIN;
        else if (st == ST_DRAIN && en)   st_nxt = ST_RUN;
      end
    endcase

    run_nxt = (st_nxt != ST_IDLE);
    v_after = (v_nxt == V_LAST) ? '0 : v_nxt + W_COORD'(1);
    vld_nxt = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
    ls_nxt  = run_nxt && (h_nxt == H_LAST) && (v_after < V_ACT);
    fs_nxt  = (st_nxt == ST_RUN) && (h_nxt == '0) && (v_nxt == '0);
    hs_nxt  = run_nxt && (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_nxt  = run_nxt && (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
  end

  // Request stage (p0): registered outputs aligned with the live h/v counters
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      st     <= ST_IDLE;
      h_cnt  <= '0;
      v_cnt  <= '0;
      vld_p0 <= 1'b0;
      ls_p0  <= 1'b0;
      fs_p0  <= 1'b0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      x_p0   <= '0;
      y_p0   <= '0;
    end else begin
      st     <= st_nxt;
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
      vld_p0 <= vld_nxt;
      ls_p0  <= ls_nxt;
      fs_p0  <= fs_nxt;
      hs_p0  <= hs_nxt;
      vs_p0  <= vs_nxt;
      x_p0   <= vld_nxt ? h_nxt : '0;
      y_p0   <= vld_nxt ? v_nxt : '0;
    end
  end

  assign running     = (st != ST_IDLE);
  assign req_valid   = vld_p0;
  assign req_x       = x_p0;
  assign req_y       = y_p0;
  assign line_start  = ls_p0;
  assign frame_start = fs_p0;

  // Timing stage: polarity applied, then delayed to meet the pixel data
  assign sync_d = {sync_level(vs_p0, VSYNC_POL), sync_level(hs_p0, HSYNC_POL), vld_p0};

  smoldvi_sync_delay #(
    .DEPTH (PIPE_LATENCY),
    .W     (3)
  ) u_sync_delay (
    .clk     (clk_pix),
    .rst     (rst_pix),
    .rst_val (BLANK),
    .d       (sync_d),
    .q       (sync_q)
  );

  assign {vsync, hsync, den} = sync_q;

endmodule

// File: tb/tb_smoldvi_timing.sv
// Randomized bench for smoldvi_timing against a frame-position reference model.
module tb_smoldvi_timing;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       d2_running, d2_req_valid, d2_line_start, d2_frame_start, d2_vsync, d2_hsync, d2_den;
  logic [9:0] d2_req_x, d2_req_y;
  logic       d0_running, d0_req_valid, d0_line_start, d0_frame_start, d0_vsync, d0_hsync, d0_den;
  logic [9:0] d0_req_x, d0_req_y;

  smoldvi_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LATENCY(2), .W_COORD(10)
  ) dut (
    .clk_pix(clk), .rst_pix(rst), .en(en), .running(d2_running),
    .req_valid(d2_req_valid), .req_x(d2_req_x), .req_y(d2_req_y),
    .line_start(d2_line_start), .frame_start(d2_frame_start),
    .vsync(d2_vsync), .hsync(d2_hsync), .den(d2_den)
  );

  smoldvi_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LATENCY(0), .W_COORD(10)
  ) dut0 (
    .clk_pix(clk), .rst_pix(rst), .en(en), .running(d0_running),
    .req_valid(d0_req_valid), .req_x(d0_req_x), .req_y(d0_req_y),
    .line_start(d0_line_start), .frame_start(d0_frame_start),
    .vsync(d0_vsync), .hsync(d0_hsync), .den(d0_den)
  );

  // Model: running flag plus linear position inside the frame; raw = {vs, hs, den} active-high.
  int         m_run = 0;
  int         m_pos = 0;
  logic [2:0] raw_hist [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_fs  = -1;
  bit fs_track = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [2:0] raw_now();
    int h, v;
    logic d, hsy, vsy;
    h   = m_pos % HT;
    v   = m_pos / HT;
    d   = (m_run != 0) && h < HA && v < VA;
    hsy = (m_run != 0) && h >= HA + HF && h < HA + HF + HS;
    vsy = (m_run != 0) && v >= VA + VF && v < VA + VF + VS;
    return {vsy, hsy, d};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run = 0;
      m_pos = 0;
      for (int i = 0; i < 3; i++) raw_hist[i] = 3'b000;
    end else begin
      if (m_run == 0) begin
        if (en) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == FRAME - 1) begin
        m_run = en ? 1 : 0;
        m_pos = 0;
      end else begin
        m_pos++;
      end
      raw_hist[2] = raw_hist[1];
      raw_hist[1] = raw_hist[0];
      raw_hist[0] = raw_now();
    end
  endtask

  task automatic check_outputs();
    int h, v;
    logic ev;
    h  = m_pos % HT;
    v  = m_pos / HT;
    ev = (m_run != 0) && h < HA && v < VA;
    chk("running",     32'(d2_running),     32'(m_run));
    chk("req_valid",   32'(d2_req_valid),   32'(ev));
    chk("req_x",       32'(d2_req_x),       ev ? 32'(h) : 32'd0);
    chk("req_y",       32'(d2_req_y),       ev ? 32'(v) : 32'd0);
    chk("line_start",  32'(d2_line_start),  32'((m_run != 0) && h == HT - 1 && ((v + 1) % VT) < VA));
    chk("frame_start", 32'(d2_frame_start), 32'((m_run != 0) && m_pos == 0));
    chk("den",         32'(d2_den),         32'(raw_hist[2][0]));
    chk("hsync",       32'(d2_hsync),       32'(!raw_hist[2][1]));
    chk("vsync",       32'(d2_vsync),       32'(!raw_hist[2][2]));
    chk("lat0_req_valid", 32'(d0_req_valid), 32'(ev));
    chk("lat0_den",    32'(d0_den),         32'(raw_hist[0][0]));
    chk("lat0_den_coinc", 32'(d0_den),      32'(d0_req_valid));
    chk("lat0_hsync",  32'(d0_hsync),       32'(!raw_hist[0][1]));
    chk("lat0_vsync",  32'(d0_vsync),       32'(!raw_hist[0][2]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (fs_track && d2_frame_start) begin
      if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
    cyc++;
  endtask

  initial begin
    int run_cnt;
    int guard;
    int targets [2];
    targets[0] = 1 * HT + 2;
    targets[1] = 1 * HT + 6;
    for (int i = 0; i < 3; i++) raw_hist[i] = 3'b000;

    rst = 1'b1; en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Continuous run: three frame periods measured
    en = 1'b1; fs_track = 1'b1;
    step();
    chk("first_fs", 32'(d2_frame_start), 32'd1);
    repeat (3 * FRAME) step();
    fs_track = 1'b0;

    // Drop en mid-frame: the frame still completes
    guard = 0;
    while (!(m_run != 0 && m_pos == 1 * HT + 2) && guard < 2 * FRAME) begin step(); guard++; end
    en = 1'b0;
    run_cnt = m_pos + 1;
    guard = 0;
    step();
    while (d2_running && guard < 2 * FRAME) begin run_cnt++; step(); guard++; end
    chk("drain_frame_len", 32'(run_cnt), 32'(FRAME));
    repeat (10) step();

    // Mid-frame resets with den or hsync in flight
    foreach (targets[k]) begin
      en = 1'b1;
      guard = 0;
      while (!(m_run != 0 && m_pos == targets[k]) && guard < 2 * FRAME) begin step(); guard++; end
      rst = 1'b1;
      step();
      chk("rst_den", 32'(d2_den), 32'd0);
      chk("rst_hsync", 32'(d2_hsync), 32'd1);
      chk("rst_vsync", 32'(d2_vsync), 32'd1);
      chk("rst_req_valid", 32'(d2_req_valid), 32'd0);
      chk("rst_running", 32'(d2_running), 32'd0);
      rst = 1'b0;
      repeat (2) begin
        step();
        chk("post_rst_den", 32'(d2_den), 32'd0);
        chk("post_rst_hsync", 32'(d2_hsync), 32'd1);
      end
    end

    // Random en toggling with occasional resets
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; en = 1'b0;
    repeat (2 * FRAME) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smoldvi_timing.md
Name: smoldvi_timing

Overview:
- Video timing controller that sequences the smoldvi DVI output path.
- Owns horizontal and vertical counters and issues per-pixel fetch requests (x, y) to the pixel source.
- Delays the sync and data-enable signals by a fixed pipeline latency so that vsync, hsync and den arrive at the smoldvi inputs aligned with the r/g/b data.
- Runs in the clk_pix domain. Starting and stopping take effect only on frame boundaries, so the link never sees a truncated frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted hsync level (0 = active-low)
- VSYNC_POL, 0, asserted vsync level (0 = active-low)
- PIPE_LATENCY, 2, clk_pix cycles from a request to pixel data valid; range 0..15
- W_COORD, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  synchronous reset, active-high
- en  in  1  run request; sampled only at frame boundary
- running  out  1  controller is generating frames
- req_valid  out  1  active-pixel fetch request this cycle
- req_x  out  W_COORD  pixel column, valid with req_valid
- req_y  out  W_COORD  pixel row, valid with req_valid
- line_start  out  1  1-cycle pulse one cycle before pixel 0 of each active line (prefetch hint)
- frame_start  out  1  1-cycle pulse on the first cycle of each frame
- vsync  out  1  to smoldvi, delayed by PIPE_LATENCY
- hsync  out  1  to smoldvi, delayed by PIPE_LATENCY
- den  out  1  to smoldvi, delayed by PIPE_LATENCY

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
- Horizontal count h, 0..H_TOTAL-1:
  - active 0..H_ACTIVE-1
  - front porch up to H_ACTIVE+H_FP-1
  - sync H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1
  - back porch for the rest
- Vertical count v uses the same ordering and increments when h wraps from H_TOTAL-1 to 0. v wraps from V_TOTAL-1 to 0.
- States:
  - IDLE: h=v=0 held; no requests; delay line fed with blank (den=0, syncs at inactive level).
  - RUN: counters advance every cycle.
  - DRAIN: counters still advance, en has fallen, and the controller is waiting for the current frame to end.
- Transitions:
  - IDLE to RUN when en=1. The first RUN cycle has h=v=0, with frame_start=1.
  - RUN to DRAIN when en=0.
  - DRAIN to RUN if en returns to 1 before the frame ends.
  - RUN or DRAIN at h=H_TOTAL-1 and v=V_TOTAL-1:
    - en=1: wrap and continue in RUN; frame_start pulses.
    - en=0: go to IDLE.
- running=1 in RUN and DRAIN.
- All request-stage outputs are registered and reflect the current (h, v):
  - req_valid = (h<H_ACTIVE) and (v<V_ACTIVE); req_x=h and req_y=v when valid, otherwise 0.
  - line_start=1 when h=H_TOTAL-1 and the next line is active (the next v is < V_ACTIVE).
  - frame_start=1 on the cycle where h=v=0 in RUN.
- Timing stage:
  - raw_den = req_valid; raw_hsync = h in the sync range; raw_vsync = v in the sync range (changes at the line boundary, h=0).
  - Polarity is applied, then the signals pass through a PIPE_LATENCY-deep shift register.
  - Output at cycle t+PIPE_LATENCY corresponds to the request at cycle t. PIPE_LATENCY=0 means the outputs are coincident with the request.
- Reset (including mid-frame):
  - next cycle: state IDLE, h=v=0, req_valid=line_start=frame_start=running=0, req_x=req_y=0
  - every delay-line stage is loaded with blank, so den=0 and hsync/vsync are at inactive levels immediately, with no stale pulses.
- en toggling mid-frame never shortens or extends a frame. Frame lengths are always exactly H_TOTAL*V_TOTAL cycles.

Decomposition:
- smoldvi_pkg holds:
  - 640x480@60 and 800x600@60 timing constants
  - state encoding localparams (IDLE, RUN, DRAIN)
  - a function computing the total from active/fp/sync/bp
- Sub-module smoldvi_sync_delay: parameterised-depth shift register for {vsync, hsync, den}, with a synchronous reset value input. Depth 0 is a pass-through.

Test Plan:
Bench parameters: H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), PIPE_LATENCY=2, active-low syncs.
- Reset, then en=1 -> first RUN cycle frame_start=1, req_valid=1, req_x=0, req_y=0; den=1 exactly 2 cycles later; the frame is 48 cycles; the next frame_start arrives 48 cycles after the first.
- Steady run -> per line: req_valid high for 4 cycles (x=0..3); hsync low at delayed positions h=5,6; line_start at h=7 of lines v=5,0,1 only.
- Vertical sync -> vsync low for the 8 cycles of v=4 (delayed by 2); den never high on v=3..5.
- en dropped at v=1,h=2 -> frame completes (48 cycles total), running falls after h=7,v=5; no frame_start follows; outputs go blank.
- rst_pix asserted at v=1,h=2 with hsync or den in flight -> the next cycle has den=0, hsync=vsync=1, req_valid=0, running=0, and no residual pulse in the following 2 cycles.
- PIPE_LATENCY=0 variant -> den is coincident with req_valid every cycle for 2 full frames.
